// File: rtl/bessel_filter_mc_if.sv
// Sample/coefficient bundle between the ADC capture side and bessel_filter_mc.
// Master drives samples and coefficient writes; slave returns filtered samples.
interface bessel_filter_mc_if #(
  parameter int ADC_WIDTH = 14,
  parameter int CHANNELS  = 2,
  parameter int COEF_W    = 16
);
  logic                          in_valid;
  logic [CHANNELS*ADC_WIDTH-1:0] adc_dat;
  logic [COEF_W:0]               coef_in;
  logic                          coef_wr;
  logic                          bypass;
  logic                          out_valid;
  logic [CHANNELS*ADC_WIDTH-1:0] adc_filt;
  logic [COEF_W:0]               coef_active;

  modport master (
    output in_valid, adc_dat, coef_in, coef_wr, bypass,
    input  out_valid, adc_filt, coef_active
  );

  modport slave (
    input  in_valid, adc_dat, coef_in, coef_wr, bypass,
    output out_valid, adc_filt, coef_active
  );
endinterface

// File: rtl/bessel_filter_mc.sv
// Multi-lane cascade of first-order low-pass sections with shadowed coefficient and bypass.
// Latency STAGES cycles from in_valid to out_valid; no backpressure, gaps in in_valid freeze the pipe.
module bessel_filter_mc #(
  parameter int ADC_WIDTH = 14,
  parameter int CHANNELS  = 2,
  parameter int STAGES    = 2,
  parameter int COEF_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int B         = 1079
) (
  input  logic               clk,
  input  logic               reset,
  bessel_filter_mc_if.slave  bus
);
  localparam int YW = ADC_WIDTH + FRAC_W;
  localparam int PW = YW + COEF_W + 2;
  localparam logic [COEF_W:0] UNITY  = {1'b1, {COEF_W{1'b0}}};
  localparam logic [COEF_W:0] B_COEF = B[COEF_W:0];

  function automatic logic signed [YW-1:0] smooth(
    input logic signed [YW-1:0] u,
    input logic signed [YW-1:0] y,
    input logic [COEF_W:0]      c
  );
    logic signed [YW:0]   diff;
    logic signed [PW-1:0] prod;
    diff = {u[YW-1], u} - {y[YW-1], y};
    prod = $signed({{(COEF_W+1){diff[YW]}}, diff}) * $signed({{(YW+1){1'b0}}, c});
    return y + YW'(prod >>> COEF_W);
  endfunction

  logic [COEF_W:0] active_q, active_d, shadow_q, shadow_d;
  logic [COEF_W:0] coef_req, coef_now;
  logic            pending_q, pending_d, primed_q, primed_d;

  // Per-sample pipeline links: index k feeds stage k, index k+1 is stage k's register.
  logic                   v_fwd  [STAGES+1];
  logic                   ld_fwd [STAGES];
  logic [COEF_W:0]        c_fwd  [STAGES];
  logic signed [YW-1:0]   u_fwd  [STAGES+1][CHANNELS];

  always_comb begin
    coef_req  = (bus.coef_in > UNITY) ? UNITY : bus.coef_in;
    coef_now  = pending_q ? shadow_q : active_q;
    shadow_d  = bus.coef_wr ? coef_req : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    primed_d  = primed_q;
    if (bus.in_valid) begin
      active_d  = coef_now;
      pending_d = 1'b0;
      primed_d  = 1'b1;
    end
    // A write landing with a sample stays pending for the following sample.
    if (bus.coef_wr) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= B_COEF;
      shadow_q  <= B_COEF;
      pending_q <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      primed_q  <= primed_d;
    end
  end

  assign v_fwd[0]  = bus.in_valid;
  assign c_fwd[0]  = coef_now;
  // Priming and bypass both load each stage straight from its input as the sample passes.
  assign ld_fwd[0] = bus.bypass | ~primed_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_in
    assign u_fwd[0][ch] = {bus.adc_dat[ch*ADC_WIDTH +: ADC_WIDTH], {FRAC_W{1'b0}}};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 v_q, v_d;
    logic signed [YW-1:0] y_q [CHANNELS];
    logic signed [YW-1:0] y_d [CHANNELS];

    always_comb begin
      v_d = v_fwd[k];
      for (int ch = 0; ch < CHANNELS; ch++) begin
        y_d[ch] = y_q[ch];
        if (v_fwd[k]) begin
          y_d[ch] = ld_fwd[k] ? u_fwd[k][ch] : smooth(u_fwd[k][ch], y_q[ch], c_fwd[k]);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
          y_q[ch] <= '0;
        end
      end else begin
        v_q <= v_d;
        for (int ch = 0; ch < CHANNELS; ch++) begin
          y_q[ch] <= y_d[ch];
        end
      end
    end

    assign v_fwd[k+1] = v_q;
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      assign u_fwd[k+1][ch] = y_q[ch];
    end

    // Coefficient and load flag ride with the sample so a stage never mixes coefficients.
    if (k < STAGES-1) begin : g_fwd
      logic [COEF_W:0] c_q, c_d;
      logic            ld_q, ld_d;

      always_comb begin
        c_d  = v_fwd[k] ? c_fwd[k]  : c_q;
        ld_d = v_fwd[k] ? ld_fwd[k] : ld_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          c_q  <= B_COEF;
          ld_q <= 1'b0;
        end else begin
          c_q  <= c_d;
          ld_q <= ld_d;
        end
      end

      assign c_fwd[k+1]  = c_q;
      assign ld_fwd[k+1] = ld_q;
    end
  end

  assign bus.out_valid   = v_fwd[STAGES];
  assign bus.coef_active = active_q;

  always_comb begin
    bus.adc_filt = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      bus.adc_filt[ch*ADC_WIDTH +: ADC_WIDTH] = u_fwd[STAGES][ch][YW-1:FRAC_W];
    end
  end
endmodule

// File: tb/tb_bessel_filter_mc.sv
// Directed bench for bessel_filter_mc: priming, unity/half coefficients, coefficient switch,
// bypass and mid-stream reset, with an in-order output scoreboard.
module tb_bessel_filter_mc;
  localparam int AW = 14;
  localparam int NC = 2;
  localparam int NS = 2;
  localparam int CW = 16;
  localparam int FW = 8;
  localparam int BC = 1079;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bessel_filter_mc_if #(.ADC_WIDTH(AW), .CHANNELS(NC), .COEF_W(CW)) bus ();

  bessel_filter_mc #(
    .ADC_WIDTH(AW), .CHANNELS(NC), .STAGES(NS),
    .COEF_W(CW), .FRAC_W(FW), .B(BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp0 [$];
  int exp1 [$];
  longint ym [NC][NS];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int b);
    exp0.push_back(a);
    exp1.push_back(b);
  endtask

  // Sample-level reference of the cascade; pushes the expected output of the sample.
  task automatic mbeat(input int a, input int b, input longint c, input bit ld);
    longint u;
    int x [NC];
    x[0] = a;
    x[1] = b;
    for (int ch = 0; ch < NC; ch++) begin
      for (int k = 0; k < NS; k++) begin
        if (k == 0) u = longint'(x[ch]) * 256;
        else        u = ym[ch][k-1];
        if (ld) ym[ch][k] = u;
        else    ym[ch][k] = ym[ch][k] + (((u - ym[ch][k]) * c) >>> CW);
      end
    end
    push(int'(ym[0][NS-1] >>> FW), int'(ym[1][NS-1] >>> FW));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int a, input int b, input bit byp);
    bus.in_valid = 1'b1;
    bus.adc_dat  = {AW'(b), AW'(a)};
    bus.bypass   = byp;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
  endtask

  task automatic write_coef(input int c);
    bus.coef_in = 17'(c);
    bus.coef_wr = 1'b1;
    @(posedge clk);
    #1;
    bus.coef_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.coef_wr  = 1'b0;
    bus.bypass   = 1'b0;
    idle(2);
    reset = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int ch = 0; ch < NC; ch++)
      for (int k = 0; k < NS; k++)
        ym[ch][k] = 0;
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp0.size() == 0) begin
        chk("unexpected_beat", int'(bus.out_valid), 0);
      end else begin
        chk("out_ch0", int'($signed(bus.adc_filt[AW-1:0])), exp0.pop_front());
        chk("out_ch1", int'($signed(bus.adc_filt[2*AW-1:AW])), exp1.pop_front());
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.adc_dat  = '0;
    bus.coef_in  = '0;
    bus.coef_wr  = 1'b0;
    bus.bypass   = 1'b0;

    // Reset state and priming latency
    do_reset();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_adc_filt", int'(bus.adc_filt), 0);
    chk("rst_coef_active", int'(bus.coef_active), BC);
    push(1000, -500);
    beat(1000, -500, 1'b0);
    chk("prime_lat1", int'(bus.out_valid), 0);
    idle(1);
    chk("prime_lat2", int'(bus.out_valid), 1);
    idle(1);
    chk("prime_lat3", int'(bus.out_valid), 0);
    repeat (3) begin
      push(1000, -500);
      beat(1000, -500, 1'b0);
    end
    idle(3);
    chk("prime_drain", exp0.size(), 0);

    // Unity coefficient tracks the input exactly
    do_reset();
    write_coef(65536);
    chk("unity_pending", int'(bus.coef_active), BC);
    push(0, 0);
    beat(0, 0, 1'b0);
    chk("unity_active", int'(bus.coef_active), 65536);
    push(8191, -8192);
    beat(8191, -8192, 1'b0);
    idle(1);
    chk("unity_lat_ch0", int'($signed(bus.adc_filt[AW-1:0])), 8191);
    chk("unity_lat_ch1", int'($signed(bus.adc_filt[2*AW-1:AW])), -8192);
    push(-3000, 4000);
    beat(-3000, 4000, 1'b0);
    idle(3);
    chk("unity_drain", exp0.size(), 0);

    // Half coefficient step response, both signs
    do_reset();
    write_coef(32768);
    push(0, 0);
    beat(0, 0, 1'b0);
    push(256, -256);
    beat(1024, -1024, 1'b0);
    push(512, -512);
    beat(1024, -1024, 1'b0);
    push(704, -704);
    beat(1024, -1024, 1'b0);
    idle(3);
    chk("half_drain", exp0.size(), 0);

    // Coefficient switch mid-stream, with gaps, then clamp
    do_reset();
    mbeat(0, 0, BC, 1'b1);
    beat(0, 0, 1'b0);
    mbeat(2000, -2000, BC, 1'b0);
    beat(2000, -2000, 1'b0);
    idle(2);
    mbeat(2000, -2000, BC, 1'b0);
    beat(2000, -2000, 1'b0);
    bus.coef_in = 17'(32768);
    bus.coef_wr = 1'b1;
    mbeat(3000, -3000, BC, 1'b0);
    beat(3000, -3000, 1'b0);
    bus.coef_wr = 1'b0;
    chk("switch_same_cycle", int'(bus.coef_active), BC);
    idle(1);
    chk("switch_wait_valid", int'(bus.coef_active), BC);
    mbeat(3000, -3000, 32768, 1'b0);
    beat(3000, -3000, 1'b0);
    chk("switch_applied", int'(bus.coef_active), 32768);
    mbeat(-5000, 5000, 32768, 1'b0);
    beat(-5000, 5000, 1'b0);
    mbeat(-5000, 5000, 32768, 1'b0);
    beat(-5000, 5000, 1'b0);
    write_coef(70000);
    mbeat(-5001, 5001, 65536, 1'b0);
    beat(-5001, 5001, 1'b0);
    chk("coef_clamp", int'(bus.coef_active), 65536);
    idle(3);
    chk("switch_drain", exp0.size(), 0);

    // Bypass window inside a step response
    do_reset();
    write_coef(32768);
    push(0, 0);
    beat(0, 0, 1'b0);
    push(256, -256);
    beat(1024, -1024, 1'b0);
    push(512, -512);
    beat(1024, -1024, 1'b0);
    push(1024, -1024);
    beat(1024, -1024, 1'b1);
    push(1100, -1100);
    beat(1100, -1100, 1'b1);
    push(1200, -1200);
    beat(1200, -1200, 1'b1);
    push(1200, -1200);
    beat(1200, -1200, 1'b0);
    push(1264, -1264);
    beat(1456, -1456, 1'b0);
    idle(3);
    chk("bypass_drain", exp0.size(), 0);

    // Reset with samples in flight, then re-prime
    do_reset();
    push(300, -300);
    beat(300, -300, 1'b0);
    beat(5000, 5000, 1'b0);
    reset = 1'b1;
    idle(1);
    chk("mid_reset_valid", int'(bus.out_valid), 0);
    reset = 1'b0;
    idle(3);
    chk("mid_reset_quiet", int'(bus.out_valid), 0);
    chk("mid_reset_coef", int'(bus.coef_active), BC);
    push(-7000, 7000);
    beat(-7000, 7000, 1'b0);
    idle(1);
    chk("reprime_ch0", int'($signed(bus.adc_filt[AW-1:0])), -7000);
    chk("reprime_ch1", int'($signed(bus.adc_filt[2*AW-1:AW])), 7000);
    idle(3);
    chk("reprime_drain", exp0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
